// File: rtl/logic_gates_pkg.sv
// logic_gates_pkg: shared states, vector table and reference results for the gate-unit sweep
package logic_gates_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_SETTLE = 2'd1;
  localparam state_t S_SAMPLE = 2'd2;
  localparam state_t S_DONE   = 2'd3;
  localparam int NUM_VEC = 4;
  // {A,B} per vector index, vector 0 in the low pair: v0=00, v1=10, v2=01, v3=11
  localparam logic [2*NUM_VEC-1:0] VEC_AB = 8'b11_01_10_00;
  function automatic logic [1:0] vec_ab(input logic [1:0] v);
    return VEC_AB[2*v +: 2];
  endfunction
  // {and, or, not} a healthy gate unit produces for inputs a, b
  function automatic logic [2:0] exp_gates(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: loadable down-counter that flags the final settle cycle
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] count_q, count_d;
  // load beats decrement; the count parks at zero so a stray enable never wraps
  always_comb count_d = load ? load_val : (en && count_q != '0) ? count_q - 1'b1 : count_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign last = (count_q == W'(1));
endmodule

// File: rtl/logic_gates_sweep_ctrl.sv
// logic_gates_sweep_ctrl: drives a gate unit through all four input vectors and checks its outputs
module logic_gates_sweep_ctrl
  import logic_gates_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iAbort,
  output logic       oA,
  output logic       oB,
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [2:0] oErrCnt,
  output logic [3:0] oFailMask,
  output logic [1:0] oVec
);
  localparam logic [DWELL_W-1:0] DWELL_V = DWELL_W'(DWELL);
  // with no settle time a vector goes straight to its sample cycle
  localparam state_t S_RUN = (DWELL == 0) ? S_SAMPLE : S_SETTLE;

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] ab_cur;
  logic       miss, cnt_load, cnt_en, cnt_last;

  assign ab_cur = vec_ab(vec_q);
  assign miss   = {iAnd, iOr, iNot} != exp_gates(ab_cur[1], ab_cur[0]);
  assign cnt_en = (state_q == S_SETTLE);

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk      (iClk),
    .rst_n    (iRst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (DWELL_V),
    .last     (cnt_last)
  );

  // sweep sequencing: start, settle countdown, sample/compare, done pulse, abort
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    mask_d   = mask_q;
    cnt_load = 1'b0;
    if (state_q == S_IDLE) begin
      if (iStart && !iAbort) begin
        state_d  = S_RUN;
        vec_d    = 2'd0;
        busy_d   = 1'b1;
        pass_d   = 1'b0;
        err_d    = 3'd0;
        mask_d   = 4'd0;
        cnt_load = 1'b1;
      end
    end else if (iAbort) begin
      state_d = S_IDLE;
      vec_d   = 2'd0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (state_q == S_SETTLE) begin
      state_d = cnt_last ? S_SAMPLE : S_SETTLE;
    end else if (state_q == S_SAMPLE) begin
      if (miss) begin
        mask_d[vec_q] = 1'b1;
        err_d         = err_q + 3'd1;
      end
      if (vec_q == 2'(NUM_VEC - 1)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = !miss && err_q == 3'd0;
      end else begin
        state_d  = S_RUN;
        vec_d    = vec_q + 2'd1;
        cnt_load = 1'b1;
      end
    end else begin
      state_d = S_IDLE;
      vec_d   = 2'd0;
    end
  end

  // the gate unit only sees a vector while settling or sampling
  always_comb {a_d, b_d} = (state_d == S_SETTLE || state_d == S_SAMPLE) ? vec_ab(vec_d) : 2'b00;

  // all outputs come straight from these registers
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end

  assign oA        = a_q;
  assign oB        = b_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oPass     = pass_q;
  assign oErrCnt   = err_q;
  assign oFailMask = mask_q;
  assign oVec      = vec_q;
endmodule

// File: tb/tb_logic_gates_sweep_ctrl.sv
// tb_logic_gates_sweep_ctrl: directed and randomized sweeps checked against a cycle-count reference
module tb_logic_gates_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n, sel, st, ab, stuck_and, not_a;
  logic [3:0][2:0] corrupt;
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1, g0, g1;
  logic [3:0] mask0, mask1;
  logic [1:0] vec0, vec1;
  logic [13:0] obs;
  logic [8:0] hold_a;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // faulty gate-unit models, one per controller, sharing the fault configuration
  assign g0 = {a0 & b0 & ~stuck_and, a0 | b0, not_a ? a0 : ~a0} ^ corrupt[{b0, a0}];
  assign g1 = {a1 & b1 & ~stuck_and, a1 | b1, not_a ? a1 : ~a1} ^ corrupt[{b1, a1}];
  assign obs = sel ? {busy1, done1, pass1, err1, mask1, vec1, a1, b1}
                   : {busy0, done0, pass0, err0, mask0, vec0, a0, b0};

  logic_gates_sweep_ctrl #(.DWELL(4), .DWELL_W(8)) dut0 (
    .iClk(clk), .iRst_n(rst_n), .iStart(st & ~sel), .iAbort(ab & ~sel),
    .oA(a0), .oB(b0), .iAnd(g0[2]), .iOr(g0[1]), .iNot(g0[0]),
    .oBusy(busy0), .oDone(done0), .oPass(pass0), .oErrCnt(err0), .oFailMask(mask0), .oVec(vec0));

  logic_gates_sweep_ctrl #(.DWELL(0), .DWELL_W(8)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(st & sel), .iAbort(ab & sel),
    .oA(a1), .oB(b1), .iAnd(g1[2]), .iOr(g1[1]), .iNot(g1[0]),
    .oBusy(busy1), .oDone(done1), .oPass(pass1), .oErrCnt(err1), .oFailMask(mask1), .oVec(vec1));

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  // error count is simply the number of failing vectors
  function automatic logic [13:0] pack(input logic busy, input logic done, input logic pass,
                                       input logic [3:0] m, input logic [1:0] v, input logic a, input logic b);
    return {busy, done, pass, 3'($countones(m)), m, v, a, b};
  endfunction

  // which vectors the configured faulty unit gets wrong compared with ideal gates
  function automatic logic [3:0] exp_fail();
    logic [3:0] m;
    logic [2:0] ideal, got;
    bit a, b;
    m = '0;
    for (int v = 0; v < 4; v++) begin
      a = (v % 2) == 1;
      b = v >= 2;
      ideal = {a && b, a || b, !a};
      got = {a && b && !stuck_and, a || b, not_a ? a : !a} ^ corrupt[v];
      m[v] = ideal != got;
    end
    return m;
  endfunction

  // one sweep of dwell d; cycle 1 follows the start-sampling edge; abort_cyc=0 means no abort
  task automatic sweep(input int d, input int abort_cyc, input bit noise);
    int t, k, seen, v, last;
    logic [3:0] fm, pm;
    logic [13:0] want;
    t = 4 * (d + 1) + 1;
    k = abort_cyc > 0 ? abort_cyc : t + 1;
    last = abort_cyc > 0 ? abort_cyc + 2 : t + 1;
    fm = exp_fail();
    @(negedge clk);
    st = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      seen = (c > k ? k : c) - 1;
      pm = '0;
      for (int u = 0; u < 4; u++) if ((u + 1) * (d + 1) <= seen) pm[u] = fm[u];
      v = (c - 1) / (d + 1);
      if (c > k) want = pack(1'b0, 1'b0, 1'b0, pm, 2'd0, 1'b0, 1'b0);
      else if (c < t) want = pack(1'b1, 1'b0, 1'b0, pm, v[1:0], v[0], v[1]);
      else if (c == t) want = pack(1'b0, 1'b1, fm == 4'd0, pm, 2'd3, 1'b0, 1'b0);
      else want = pack(1'b0, 1'b0, fm == 4'd0, pm, 2'd0, 1'b0, 1'b0);
      chk($sformatf("sweep d%0d ab%0d c%0d", d, abort_cyc, c), obs, want);
      st = (noise && c <= k && c <= t) ? 1'($urandom_range(0, 1)) : 1'b0;
      ab = (c == abort_cyc);
    end
    st = 1'b0;
    ab = 1'b0;
  endtask

  task automatic reset_mid(input string tag);
    #1 rst_n = 1'b0;
    #1 chk({tag, " async"}, obs, 14'd0);
    @(negedge clk);
    chk({tag, " held"}, obs, 14'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, " released"}, obs, 14'd0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; st = 1'b0; ab = 1'b0;
    stuck_and = 1'b0; not_a = 1'b0; corrupt = '0;
    hold_a = 9'b100010100;
    #3 chk("reset inst0", obs, 14'd0);
    sel = 1'b1;
    #1 chk("reset inst1", obs, 14'd0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle after reset", obs, 14'd0);
    sweep(4, 0, 1'b0);
    stuck_and = 1'b1;
    sweep(4, 0, 1'b0);
    stuck_and = 1'b0;
    not_a = 1'b1;
    sweep(4, 0, 1'b0);
    not_a = 1'b0;
    sweep(4, 8, 1'b0);
    sweep(4, 0, 1'b0);
    @(negedge clk);
    st = 1'b1; ab = 1'b1;
    @(negedge clk);
    st = 1'b0; ab = 1'b0;
    chk("abort beats start", obs, pack(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    chk("abort beats start idle", obs, pack(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy before reset d4", obs, pack(1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0));
    reset_mid("rst d4");
    sel = 1'b1;
    sweep(0, 0, 1'b0);
    stuck_and = 1'b1;
    sweep(0, 0, 1'b0);
    stuck_and = 1'b0;
    @(negedge clk);
    st = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("held start c%0d", c), {12'd0, a1, done1}, {12'd0, hold_a[c], 1'(c == 5)});
    end
    st = 1'b0;
    @(negedge clk);
    chk("busy before reset d0", obs, pack(1'b1, 1'b0, 1'b0, 4'd0, 2'd2, 1'b0, 1'b1));
    reset_mid("rst d0");
    repeat (30) begin
      int d, ac;
      sel = 1'($urandom_range(0, 1));
      stuck_and = ($urandom_range(0, 3) == 0);
      not_a = ($urandom_range(0, 3) == 0);
      for (int v = 0; v < 4; v++) corrupt[v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      d = sel ? 0 : 4;
      ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * (d + 1) + 1)) : 0;
      sweep(d, ac, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/logic_gates_sweep_ctrl.md
Name: logic_gates_sweep_ctrl

Overview:
Self-test sequencer for the two-input gate unit (inputs iA/iB; outputs oAnd/oOr/oNot). On a start request it drives the unit through all four input vectors, holds each vector for a programmable settle time, then samples the three gate outputs and compares them against expected values. It reports busy, a done pulse, pass/fail, an error count and a per-vector fail mask. It sits between the board-level control logic and one gate-unit instance.

Parameters:
DWELL, 4, settle cycles per vector before the sample cycle; legal range 0..255
DWELL_W, 8, width of the dwell counter; must hold DWELL

Ports:
iClk  in  1  system clock, rising edge
iRst_n  in  1  asynchronous, active-low reset
iStart  in  1  start request, sampled only in IDLE
iAbort  in  1  synchronous abort, valid in any state
oA  out  1  drives gate-unit iA
oB  out  1  drives gate-unit iB
iAnd  in  1  from gate-unit oAnd
iOr  in  1  from gate-unit oOr
iNot  in  1  from gate-unit oNot
oBusy  out  1  high while a sweep is in progress
oDone  out  1  one-cycle pulse when a sweep completes
oPass  out  1  result of the last completed sweep; 1 = no mismatches
oErrCnt  out  3  number of failing vectors in the current or last sweep, 0..4
oFailMask  out  4  bit v set = vector v failed
oVec  out  2  current vector index

Behaviour:
- Reset (iRst_n=0, asynchronous): state IDLE; oA, oB, oBusy, oDone, oPass = 0; oErrCnt = 0; oFailMask = 0; oVec = 0; dwell counter = 0. A reset mid-sweep takes effect immediately.
- All outputs are registered.
- Vector order by index v: v0 {A,B}=00, v1 10, v2 01, v3 11. So oA = v[0] and oB = v[1].
- Expected results: and = A&B; or = A|B; not = ~A.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - oA = oB = 0, oBusy = 0.
  - iStart=1 and iAbort=0: at the next edge go to SETTLE with v=0. On that same edge, load the counter with DWELL, clear oErrCnt/oFailMask/oPass, set oBusy=1 and drive vector 0.
  - If DWELL=0, go directly to SAMPLE instead of SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to SAMPLE at the next edge.
  - The vector is held stable for exactly DWELL cycles in SETTLE.
- SAMPLE (one cycle):
  - At the closing edge, compare iAnd/iOr/iNot with expected values for v.
  - Any mismatch sets oFailMask[v] and increments oErrCnt (saturates at 4 by construction).
  - If v<3: v+1, drive the new vector, reload the counter, go to SETTLE (or SAMPLE if DWELL=0).
  - If v=3: go to DONE.
- Each vector is therefore held DWELL+1 cycles.
- DONE (one cycle):
  - oDone=1, oPass = (oErrCnt==0), oBusy=0, oA = oB = 0.
  - Return to IDLE at the next edge.
  - oDone is high in cycle 4*(DWELL+1)+1, counting the cycle after the iStart-sampling edge as cycle 1 (21 for DWELL=4).
- oPass, oErrCnt and oFailMask hold until the next accepted iStart.
- iStart outside IDLE: ignored and not queued.
- iAbort=1 in SETTLE/SAMPLE/DONE: go to IDLE at the next edge.
  - oBusy=0, oA = oB = 0, no oDone pulse, oPass=0.
  - oErrCnt and oFailMask keep their partial values.
- iAbort and iStart both high in IDLE: abort wins; stay IDLE.
- iAbort and the SAMPLE compare in the same cycle: the compare result for that vector is discarded.
- oVec equals v at all times; it returns to 0 in IDLE.

Decomposition:
- Package logic_gates_pkg:
  - state enumeration
  - NUM_VEC=4
  - vector-to-{A,B} mapping constant
  - expected-result function exp_gates(A,B) returning {and,or,not}
- Sub-module dwell_counter: loadable DWELL_W-bit down-counter with load, enable and a last-cycle (count==1) flag. It is instantiated once.

Test Plan:
1. Reset: assert iRst_n=0 mid-cycle -> all outputs 0 immediately, state IDLE. Release -> outputs stay 0 until iStart.
2. Correct gate model, DWELL=4, iStart pulsed for one cycle -> oA/oB = 00,10,01,11, each held 5 cycles. oDone pulses in cycle 21; oPass=1, oErrCnt=0, oFailMask=0000, oBusy high cycles 1..20.
3. Gate model with oAnd stuck-at-0 -> only v3 fails: oFailMask=1000, oErrCnt=1, oPass=0.
4. Gate model with oNot=A (not inverted) -> every vector fails: oFailMask=1111, oErrCnt=4, oPass=0.
5. iAbort in cycle 8 (v1 settling) -> IDLE next edge, oBusy=0, oA=oB=0, no oDone, oFailMask=0000. A following iStart completes a clean sweep with oPass=1.
6. DWELL=0 -> each vector held 1 cycle, oDone in cycle 5. iStart held high throughout -> a second sweep starts only after returning to IDLE (first oA change at cycle 8). Async reset at cycle 3 -> immediate return to reset values.
